// File: rtl/phase_pkg.sv
// ----------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the two-phase clock receive path.
//   - FSM state encoding (2 bits): HUNT, WAIT_PH2, WAIT_PH1
//   - CYCLE_STEPS_DEF: machine-cycle length used by the clock generator
// ----------------------------------------------------------------------------
package phase_pkg;

   localparam logic [1:0] HUNT     = 2'd0;
   localparam logic [1:0] WAIT_PH2 = 2'd1;
   localparam logic [1:0] WAIT_PH1 = 2'd2;

   // PH1->PH2 pairs per machine cycle, as produced by the generator
   localparam int CYCLE_STEPS_DEF = 8;

endpackage

// File: rtl/phase_edge_det.sv
// ----------------------------------------------------------------------------
// phase_edge_det
// Registers one level input and strobes on its transition.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset (registered level clears to 0)
//   i_d     : level input, synchronous to i_clk
//   o_edge  : FALL=0 -> i_d & ~q (rise), FALL=1 -> ~i_d & q (fall)
// ----------------------------------------------------------------------------
module phase_edge_det #(
   parameter bit FALL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_edge
);

   logic r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_q <= 1'b0;
      else       r_q <= i_d;
   end

   assign o_edge = FALL ? (~i_d & r_q) : (i_d & ~r_q);

endmodule

// File: rtl/phase_decoder.sv
// ----------------------------------------------------------------------------
// phase_decoder
// Receive side of the two-phase non-overlapping clock (PH1/PH2 + O_S toggle).
// Checks phase ordering / non-overlap / liveness, declares lock, tracks the
// step index within the machine cycle and pulses SYNC at machine-cycle start.
//   i_clk, i_rst    : system clock, synchronous active-high reset
//   i_ph1, i_ph2    : phase levels sampled on i_clk
//   i_o_s           : generator phase toggle; its fall at PH1 aligns STEP to 0
//   i_clr_err       : clears the sticky error flags
//   o_step          : step index within the machine cycle
//   o_sync          : one-cycle pulse on the PH1 rise of step 0 while locked
//   o_locked        : phase stream valid
//   o_err_overlap   : sticky, PH1 and PH2 high together
//   o_err_order     : sticky, same phase rose twice in a row
//   o_err_stall     : sticky, no phase rise for TIMEOUT cycles
// All outputs are registered: a sampled rise shows up one cycle later.
// ----------------------------------------------------------------------------
module phase_decoder
   import phase_pkg::*;
#(
   parameter  int CYCLE_STEPS = CYCLE_STEPS_DEF,
   parameter  int LOCK_COUNT  = 4,
   parameter  int TIMEOUT     = 15,
   localparam int SW          = $clog2(CYCLE_STEPS)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_ph1,
   input  logic          i_ph2,
   input  logic          i_o_s,
   input  logic          i_clr_err,
   output logic [SW-1:0] o_step,
   output logic          o_sync,
   output logic          o_locked,
   output logic          o_err_overlap,
   output logic          o_err_order,
   output logic          o_err_stall
);

   logic [1:0]    r_state;
   logic [3:0]    r_pair;
   logic [7:0]    r_tmo;
   logic [SW-1:0] r_step;
   logic          r_sync, r_locked, r_err_ov, r_err_or, r_err_st;

   logic          w_r1, w_r2, w_os_fall;
   logic          w_overlap, w_stall, w_order, w_fault;
   logic [1:0]    w_state_nx;
   logic [3:0]    w_pair_nx;
   logic [7:0]    w_tmo_nx;
   logic [SW-1:0] w_step_nx;
   logic          w_sync_nx, w_locked_nx;

   phase_edge_det #(.FALL(1'b0)) u_ph1 (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_ph1), .o_edge(w_r1));
   phase_edge_det #(.FALL(1'b0)) u_ph2 (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_ph2), .o_edge(w_r2));
   phase_edge_det #(.FALL(1'b1)) u_os  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_o_s), .o_edge(w_os_fall));

   always_comb begin
      w_overlap = i_ph1 & i_ph2;
      // counter hits TIMEOUT on this edge if no rise arrives
      w_stall   = (r_state != HUNT) & ~w_r1 & ~w_r2 & (r_tmo >= 8'(TIMEOUT - 1));
      // simultaneous rises always imply overlap, which outranks order
      w_order   = ((r_state == WAIT_PH2) & w_r1) | ((r_state == WAIT_PH1) & w_r2);
      w_fault   = w_overlap | w_stall | w_order;

      w_state_nx = r_state;
      w_pair_nx  = r_pair;
      w_tmo_nx   = r_tmo;
      w_step_nx  = r_step;
      w_sync_nx  = 1'b0;

      if (w_fault) begin
         w_state_nx = HUNT;
         w_pair_nx  = '0;
         w_tmo_nx   = '0;
         w_step_nx  = '0;
      end else begin
         if (r_state != HUNT) begin
            if (w_r1 | w_r2)                 w_tmo_nx = '0;
            else if (r_tmo < 8'(TIMEOUT))    w_tmo_nx = r_tmo + 8'd1;
         end
         case (r_state)
            HUNT: begin
               w_pair_nx = '0;
               w_tmo_nx  = '0;
               w_step_nx = '0;
               if (w_r1) w_state_nx = WAIT_PH2;
            end
            WAIT_PH2: if (w_r2) begin
               w_state_nx = WAIT_PH1;
               if (r_pair < 4'(LOCK_COUNT)) w_pair_nx = r_pair + 4'd1;
               // the pair that completes lock does not advance STEP
               if (r_locked)
                  w_step_nx = (r_step == SW'(CYCLE_STEPS - 1)) ? '0 : r_step + 1'b1;
            end
            WAIT_PH1: if (w_r1) begin
               w_state_nx = WAIT_PH2;
               if (w_os_fall) w_step_nx = '0;
               w_sync_nx = r_locked & (w_step_nx == '0);
            end
            default: w_state_nx = HUNT;
         endcase
      end

      w_locked_nx = (w_pair_nx == 4'(LOCK_COUNT)) & (w_state_nx != HUNT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= HUNT;
         r_pair   <= '0;
         r_tmo    <= '0;
         r_step   <= '0;
         r_sync   <= 1'b0;
         r_locked <= 1'b0;
         r_err_ov <= 1'b0;
         r_err_or <= 1'b0;
         r_err_st <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_pair   <= w_pair_nx;
         r_tmo    <= w_tmo_nx;
         r_step   <= w_step_nx;
         r_sync   <= w_sync_nx;
         r_locked <= w_locked_nx;
         // only the highest-priority fault is flagged; a fault beats CLR_ERR
         r_err_ov <= (r_err_ov & ~i_clr_err) | w_overlap;
         r_err_st <= (r_err_st & ~i_clr_err) | (w_stall & ~w_overlap);
         r_err_or <= (r_err_or & ~i_clr_err) | (w_order & ~w_overlap & ~w_stall);
      end
   end

   assign o_step        = r_step;
   assign o_sync        = r_sync;
   assign o_locked      = r_locked;
   assign o_err_overlap = r_err_ov;
   assign o_err_order   = r_err_or;
   assign o_err_stall   = r_err_st;

endmodule

// File: tb/tb_phase_decoder.sv
// ----------------------------------------------------------------------------
// tb_phase_decoder
// Scoreboard bench: every driven cycle a behavioural model pushes the expected
// output word; it is popped and compared one edge later. Directed checks pin
// the key scenarios to absolute values.
// ----------------------------------------------------------------------------
module tb_phase_decoder;

   localparam int CS   = 8;
   localparam int LOCK = 4;
   localparam int TMO  = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ph1 = 1'b0, ph2 = 1'b0, o_s = 1'b0, clr = 1'b0;
   logic [2:0] step;
   logic       sync, locked, e_ov, e_or, e_st;

   always #5 clk = ~clk;

   phase_decoder #(.CYCLE_STEPS(CS), .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .i_ph1(ph1), .i_ph2(ph2), .i_o_s(o_s),
      .i_clr_err(clr), .o_step(step), .o_sync(sync), .o_locked(locked),
      .o_err_overlap(e_ov), .o_err_order(e_or), .o_err_stall(e_st)
   );

   int n_chk = 0, n_err = 0, sync_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // behavioural model state (0=hunt, 1=waiting PH2, 2=waiting PH1)
   int m_st = 0, m_pair = 0, m_tmo = 0, m_step = 0;
   bit m_lock = 0, m_sync = 0, m_ov = 0, m_or = 0, m_stl = 0;
   bit q1 = 0, q2 = 0, qo = 0;

   task automatic model(input bit p1, p2, os, c, r);
      bit a1, a2, fall, ov, stl, ord, was_lock;
      if (r) begin
         m_st = 0; m_pair = 0; m_tmo = 0; m_step = 0;
         m_lock = 0; m_sync = 0; m_ov = 0; m_or = 0; m_stl = 0;
         q1 = 0; q2 = 0; qo = 0;
         return;
      end
      a1 = p1 && !q1; a2 = p2 && !q2; fall = !os && qo;
      ov  = p1 && p2;
      stl = (m_st != 0) && !a1 && !a2 && (m_tmo + 1 >= TMO);
      ord = (m_st == 1 && a1) || (m_st == 2 && a2);
      if (c) begin m_ov = 0; m_or = 0; m_stl = 0; end
      if (ov)       m_ov  = 1;
      else if (stl) m_stl = 1;
      else if (ord) m_or  = 1;
      was_lock = m_lock;
      m_sync = 0;
      if (ov || stl || ord) begin
         m_st = 0; m_pair = 0; m_tmo = 0; m_step = 0;
      end else if (m_st == 0) begin
         if (a1) m_st = 1;
      end else begin
         m_tmo = (a1 || a2) ? 0 : ((m_tmo < TMO) ? m_tmo + 1 : TMO);
         if (m_st == 1 && a2) begin
            m_st = 2;
            if (m_pair < LOCK) m_pair++;
            if (was_lock) m_step = (m_step + 1) % CS;
         end else if (m_st == 2 && a1) begin
            m_st = 1;
            if (fall) m_step = 0;
            if (was_lock && m_step == 0) m_sync = 1;
         end
      end
      m_lock = (m_pair == LOCK) && (m_st != 0);
      q1 = p1; q2 = p2; qo = os;
   endtask

   task automatic drive(input bit p1, p2, os = 0, c = 0, r = 0);
      logic [7:0] e;
      ph1 = p1; ph2 = p2; o_s = os; clr = c; rst = r;
      model(p1, p2, os, c, r);
      exp_q.push_back({3'(m_step), m_sync, m_lock, m_ov, m_or, m_stl});
      @(posedge clk); #1;
      if (exp_q.size() == 0) chk("sb_empty", 0, 1);
      else begin
         e = exp_q.pop_front();
         chk("sb", {24'd0, step, sync, locked, e_ov, e_or, e_st}, {24'd0, e});
      end
      if (sync) sync_cnt++;
   endtask

   task automatic pairs(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 0); drive(1, 0); drive(0, 0); drive(0, 0);
         drive(0, 1); drive(0, 1); drive(0, 0); drive(0, 0);
      end
   endtask

   task automatic missing_ph2();
      drive(1, 0); drive(1, 0); drive(0, 0); drive(0, 0);
      drive(1, 0); drive(1, 0); drive(0, 0); drive(0, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_step"}, step, 0);
      chk({tag, "_sync"}, sync, 0);
      chk({tag, "_lock"}, locked, 0);
      chk({tag, "_ov"}, e_ov, 0);
      chk({tag, "_or"}, e_or, 0);
      chk({tag, "_st"}, e_st, 0);
   endtask

   initial begin
      // reset
      drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
      chk_all_zero("rst");

      // lock exactly one cycle after the 4th PH2 rise
      pairs(3);
      drive(1, 0); drive(1, 0); drive(0, 0); drive(0, 0);
      chk("prelock", locked, 0);
      drive(0, 1);
      chk("lock_4th", locked, 1);
      chk("lock_step", step, 0);
      drive(0, 1); drive(0, 0); drive(0, 0);

      // two full machine cycles: one SYNC per 8 pairs, STEP wraps
      sync_cnt = 0;
      pairs(16);
      chk("sync_cnt", sync_cnt, 2);
      chk("wrap_step", step, 0);
      pairs(3);
      chk("step3", step, 3);

      // overlap together with CLR_ERR: fault wins
      drive(1, 1, 0, 1);
      chk("ov_flag", e_ov, 1);
      chk("ov_lock", locked, 0);
      chk("ov_step", step, 0);
      drive(0, 0);
      pairs(4);
      chk("ov_relock", locked, 1);
      chk("ov_sticky", e_ov, 1);
      drive(0, 0, 0, 1);
      chk("ov_clr", e_ov, 0);

      // order: PH2 pulse dropped
      pairs(1);
      missing_ph2();
      chk("or_flag", e_or, 1);
      chk("or_lock", locked, 0);
      chk("or_ov", e_ov, 0);
      chk("or_st", e_st, 0);
      drive(0, 0, 0, 1);

      // stall: 16 idle cycles while locked
      pairs(4);
      chk("st_prelock", locked, 1);
      for (int i = 0; i < 16; i++) drive(0, 0);
      chk("st_flag", e_st, 1);
      chk("st_lock", locked, 0);
      pairs(4);
      chk("st_relock", locked, 1);
      drive(0, 0, 0, 1);

      // alignment: O_S falls on the PH1 rise while STEP=5
      pairs(5);
      chk("al_step5", step, 5);
      drive(0, 0, 1);
      drive(1, 0, 0);
      chk("al_step", step, 0);
      chk("al_sync", sync, 1);
      drive(1, 0); drive(0, 0); drive(0, 0);
      drive(0, 1); drive(0, 1); drive(0, 0); drive(0, 0);

      // reset mid-operation at STEP=6 with ERR_ORDER set
      missing_ph2();
      pairs(4);
      pairs(6);
      chk("rs_step6", step, 6);
      chk("rs_or", e_or, 1);
      chk("rs_lock", locked, 1);
      drive(0, 0, 0, 0, 1);
      chk_all_zero("rs");
      pairs(3);
      chk("rs_nolock", locked, 0);
      pairs(1);
      chk("rs_relock", locked, 1);
      chk("rs_step0", step, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
